// File: rtl/br_generator_frac.sv
// UART baud-tick generator with a fractional divisor.
// Produces an oversampling tick plus mid-bit and end-of-bit strobes. The
// divisor is double-buffered: writes land in a shadow copy and move into the
// active copy at a tick, a phase restart, or immediately while disabled.
module br_generator_frac #(
    parameter longint unsigned CLK_FREQ   = 64'd100000000,
    parameter int unsigned     BAUD_RATE  = 32'd9600,
    parameter int unsigned     OVERSAMPLE = 32'd16,
    parameter int unsigned     INT_NBITS  = 32'd16,
    parameter int unsigned     FRAC_NBITS = 32'd4,
    parameter longint unsigned DEF_INT    = CLK_FREQ / (64'(OVERSAMPLE) * 64'(BAUD_RATE)),
    parameter longint unsigned DEF_FRAC   =
        ((CLK_FREQ % (64'(OVERSAMPLE) * 64'(BAUD_RATE))) * (64'd2 << FRAC_NBITS)
         + 64'(OVERSAMPLE) * 64'(BAUD_RATE))
        / (64'd2 * 64'(OVERSAMPLE) * 64'(BAUD_RATE))
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_sync,
    input  logic                  i_div_wr,
    input  logic [INT_NBITS-1:0]  i_div_int,
    input  logic [FRAC_NBITS-1:0] i_div_frac,
    output logic                  o_tick,
    output logic                  o_mid_tick,
    output logic                  o_bit_tick,
    output logic                  o_div_pend
);

    localparam int unsigned SUB_W = $clog2(OVERSAMPLE);

    // Rounding of the default fraction can reach 2^FRAC_NBITS; fold that
    // overflow back into the integer part so the default stays accurate.
    localparam longint unsigned DEF_CARRY = DEF_FRAC >> FRAC_NBITS;

    localparam logic [INT_NBITS-1:0]  DEF_INT_C  = INT_NBITS'(DEF_INT + DEF_CARRY);
    localparam logic [FRAC_NBITS-1:0] DEF_FRAC_C = FRAC_NBITS'(DEF_FRAC);
    localparam logic [INT_NBITS-1:0]  ZERO_I     = INT_NBITS'(0);
    localparam logic [INT_NBITS-1:0]  ONE_I      = INT_NBITS'(1);
    localparam logic [INT_NBITS-1:0]  TWO_I      = INT_NBITS'(2);
    localparam logic [FRAC_NBITS-1:0] ZERO_F     = FRAC_NBITS'(0);
    localparam logic [SUB_W-1:0]      ZERO_SUB   = SUB_W'(0);
    localparam logic [SUB_W-1:0]      ONE_SUB    = SUB_W'(1);
    localparam logic [SUB_W-1:0]      MID_SUB    = SUB_W'(OVERSAMPLE / 32'd2 - 32'd1);
    localparam logic [SUB_W-1:0]      LAST_SUB   = SUB_W'(OVERSAMPLE - 32'd1);

    // A divisor below 2 would leave no idle cycle between ticks.
    function automatic logic [INT_NBITS-1:0] clamp_int(input logic [INT_NBITS-1:0] v);
        logic [INT_NBITS-1:0] r;
        if (v < TWO_I) begin
            r = TWO_I;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [INT_NBITS-1:0]  cnt_q,   cnt_d;
    logic [FRAC_NBITS-1:0] acc_q,   acc_d;
    logic [SUB_W-1:0]      sub_q,   sub_d;
    logic [INT_NBITS-1:0]  aint_q,  aint_d;
    logic [FRAC_NBITS-1:0] afrac_q, afrac_d;
    logic [INT_NBITS-1:0]  sint_q,  sint_d;
    logic [FRAC_NBITS-1:0] sfrac_q, sfrac_d;
    logic                  pend_q,  pend_d;

    logic                  tick_s;
    logic                  apply_s;
    logic                  new_div_s;
    logic [INT_NBITS-1:0]  sh_int_s;
    logic [FRAC_NBITS-1:0] sh_frac_s;
    logic [FRAC_NBITS:0]   acc_sum_s;

    // Next-state: shadow capture, divisor apply, phase restart, tick reload, count-down.
    always_comb begin
        sh_int_s  = i_div_wr ? clamp_int(i_div_int) : sint_q;
        sh_frac_s = i_div_wr ? i_div_frac : sfrac_q;
        new_div_s = pend_q | i_div_wr;
        tick_s    = i_en & ~i_sync & (cnt_q == ZERO_I);
        apply_s   = i_sync | tick_s | (~i_en & pend_q);
        acc_sum_s = {1'b0, acc_q} + {1'b0, afrac_q};

        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sub_d   = sub_q;
        aint_d  = aint_q;
        afrac_d = afrac_q;
        sint_d  = sh_int_s;
        sfrac_d = sh_frac_s;
        pend_d  = new_div_s;

        if (apply_s && new_div_s) begin
            // A fresh divisor takes over and restarts the phase.
            aint_d  = sh_int_s;
            afrac_d = sh_frac_s;
            cnt_d   = sh_int_s - ONE_I;
            acc_d   = ZERO_F;
            sub_d   = ZERO_SUB;
            pend_d  = 1'b0;
        end else if (i_sync) begin
            cnt_d   = aint_q - ONE_I;
            acc_d   = ZERO_F;
            sub_d   = ZERO_SUB;
            pend_d  = 1'b0;
        end else if (tick_s) begin
            // Accumulator carry stretches the next period by one clock.
            acc_d = acc_sum_s[FRAC_NBITS-1:0];
            cnt_d = aint_q - ONE_I + {{(INT_NBITS-1){1'b0}}, acc_sum_s[FRAC_NBITS]};
            sub_d = sub_q + ONE_SUB;
        end else if (i_en) begin
            cnt_d = cnt_q - ONE_I;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset to the default divisor.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q   <= DEF_INT_C - ONE_I;
            acc_q   <= ZERO_F;
            sub_q   <= ZERO_SUB;
            aint_q  <= DEF_INT_C;
            afrac_q <= DEF_FRAC_C;
            sint_q  <= DEF_INT_C;
            sfrac_q <= DEF_FRAC_C;
            pend_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            aint_q  <= aint_d;
            afrac_q <= afrac_d;
            sint_q  <= sint_d;
            sfrac_q <= sfrac_d;
            pend_q  <= pend_d;
        end
    end

    assign o_tick     = tick_s;
    assign o_mid_tick = tick_s & (sub_q == MID_SUB);
    assign o_bit_tick = tick_s & (sub_q == LAST_SUB);
    assign o_div_pend = pend_q;

endmodule

// File: tb/tb_br_generator_frac.sv
`timescale 1ns/1ps
module tb_br_generator_frac;

    localparam int OS     = 16;
    localparam int FSCALE = 16;
    localparam int D_INT  = 651;
    localparam int D_FRAC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, sync, wr;
    logic [15:0] dint;
    logic [3:0]  dfrac;
    logic        tick, mid, bitt, pend;

    int checks = 0;
    int errors = 0;

    br_generator_frac dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_en       (en),
        .i_sync     (sync),
        .i_div_wr   (wr),
        .i_div_int  (dint),
        .i_div_frac (dfrac),
        .o_tick     (tick),
        .o_mid_tick (mid),
        .o_bit_tick (bitt),
        .o_div_pend (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wi;
        int wf;
        int period;
        int total;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic e, input logic s, input logic w, input int wi, input int wf);
        @(posedge clk);
        #1;
        en = e; sync = s; wr = w; dint = 16'(wi); dfrac = 4'(wf);
        @(negedge clk);
    endtask

    task automatic run_to_tick(output int n, output logic m, output logic b);
        n = 0;
        do begin
            cyc(1'b1, 1'b0, 1'b0, 0, 0);
            n++;
        end while (!tick && n < 5000);
        m = mid;
        b = bitt;
        if (!tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick after %0d cycles", n);
        end
    endtask

    // Reference model: elapsed enabled cycles vs target period, ticks since restart.
    int m_aint, m_afrac, m_sint, m_sfrac, m_e, m_p, m_fsum, m_n;
    bit m_pend;

    function automatic void model_reset();
        m_aint = D_INT; m_afrac = D_FRAC; m_sint = D_INT; m_sfrac = D_FRAC;
        m_pend = 1'b0; m_e = 0; m_p = D_INT; m_fsum = 0; m_n = 0;
    endfunction

    function automatic bit model_tick(input bit e, input bit s);
        return e && !s && (m_e == m_p - 1);
    endfunction

    function automatic void model_step(input bit e, input bit s, input bit w, input int wi, input int wf);
        bit t, fresh, apply;
        int sum;
        t = model_tick(e, s);
        if (w) begin
            m_sint  = (wi < 2) ? 2 : wi;
            m_sfrac = wf;
        end
        fresh = m_pend || w;
        apply = s || t || (!e && m_pend);
        if (apply && fresh) begin
            m_aint = m_sint; m_afrac = m_sfrac;
            m_e = 0; m_p = m_aint; m_fsum = 0; m_n = 0; m_pend = 1'b0;
        end else if (s) begin
            m_e = 0; m_p = m_aint; m_fsum = 0; m_n = 0; m_pend = 1'b0;
        end else if (t) begin
            sum    = m_fsum + m_afrac;
            m_fsum = sum % FSCALE;
            m_e    = 0;
            m_p    = m_aint + ((sum >= FSCALE) ? 1 : 0);
            m_n    = m_n + 1;
        end else begin
            if (e) m_e = m_e + 1;
            m_pend = fresh;
        end
    endfunction

    initial begin
        int n, n652, nodd, first_mid, first_bit, tot, strobes;
        logic m, b;
        bit pend_ok, per_ok;
        logic [3:0] exp_out;

        vecs[0] = '{10,  8, 10, 167};
        vecs[1] = '{ 0,  0,  2,  32};
        vecs[2] = '{ 1,  5,  2,  36};
        vecs[3] = '{ 5,  4,  5,  83};
        vecs[4] = '{ 3, 15,  3,  62};
        vecs[5] = '{ 7,  0,  7, 112};

        // Reset state
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; wr = 1'b0; dint = 16'd0; dfrac = 4'd0;
        #23;
        check("rst_tick", tick, 0);
        check("rst_mid", mid, 0);
        check("rst_bit", bitt, 0);
        check("rst_pend", pend, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default divisor: 651 cycles, one 652 in 16 intervals, mid on 8th, bit on 16th
        n652 = 0; nodd = 0; first_mid = 0; first_bit = 0;
        for (int k = 1; k <= 17; k++) begin
            run_to_tick(n, m, b);
            if (k == 1) check("first_period", n, D_INT);
            else if (n == 652) n652++;
            else if (n != 651) nodd++;
            if (m && first_mid == 0) first_mid = k;
            if (b && first_bit == 0) first_bit = k;
        end
        check("def_652_count", n652, 1);
        check("def_odd_periods", nodd, 0);
        check("def_first_mid", first_mid, 8);
        check("def_first_bit", first_bit, 16);

        // Mid-period write 10/8: pending until next tick, then 10/11 periods
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b1, 10, 8);
        pend_ok = 1'b1; n = 0;
        do begin
            cyc(1'b1, 1'b0, 1'b0, 0, 0);
            n++;
            if (!pend) pend_ok = 1'b0;
        end while (!tick && n < 5000);
        check("wr_pend_held", pend_ok, 1);
        tot = 0; per_ok = 1'b1; first_mid = 0; first_bit = 0;
        for (int k = 1; k <= 16; k++) begin
            run_to_tick(n, m, b);
            tot += n;
            if (k == 1) begin
                check("wr_pend_clear", pend, 0);
                check("wr_first_period", n, 10);
            end
            if (n != 10 && n != 11) per_ok = 1'b0;
            if (m && first_mid == 0) first_mid = k;
            if (b && first_bit == 0) first_bit = k;
        end
        check("wr_period_set", per_ok, 1);
        check("wr_total16", tot, 167);
        check("wr_first_bit", first_bit, 16);
        check("wr_first_mid", first_mid, 8);

        // Enable dropped for 100 cycles with cnt=5
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, 0);
            if (tick | mid | bitt) strobes++;
        end
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 0, 0);
            if (tick | mid | bitt) strobes++;
        end
        run_to_tick(n, m, b);
        check("en_hold_strobes", strobes, 0);
        check("en_resume_cnt", n, 6);

        // Sync on the cnt==0 cycle suppresses the tick and restarts the phase
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        check("sync_no_tick", tick, 0);
        run_to_tick(n, m, b);
        check("sync_next_period", n, 10);
        check("sync_sub0", {m, b}, 0);

        // Table: write together with sync, 16 ticks after apply
        foreach (vecs[i]) begin
            cyc(1'b1, 1'b1, 1'b1, vecs[i].wi, vecs[i].wf);
            tot = 0; first_mid = 0; first_bit = 0;
            for (int k = 1; k <= 16; k++) begin
                run_to_tick(n, m, b);
                tot += n;
                if (k == 1) begin
                    check($sformatf("vec%0d_pend", i), pend, 0);
                    check($sformatf("vec%0d_period", i), n, vecs[i].period);
                end
                if (m && first_mid == 0) first_mid = k;
                if (b && first_bit == 0) first_bit = k;
            end
            check($sformatf("vec%0d_total", i), tot, vecs[i].total);
            check($sformatf("vec%0d_bit", i), first_bit, 16);
            check($sformatf("vec%0d_mid", i), first_mid, 8);
        end

        // Asynchronous reset in the middle of a tick cycle with a write pending
        cyc(1'b1, 1'b0, 1'b1, 9, 3);
        run_to_tick(n, m, b);
        check("pre_rst_tick", tick, 1);
        check("pre_rst_pend", pend, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_mid", mid, 0);
        check("arst_bit", bitt, 0);
        check("arst_pend", pend, 0);
        en = 1'b0; sync = 1'b0; wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_to_tick(n, m, b);
        check("arst_default_period", n, D_INT);

        // Randomised run against the reference model
        rst_n = 1'b0;
        en = 1'b0; sync = 1'b0; wr = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20000; i++) begin
            bit e, s, w;
            int wi, wf;
            e  = ($urandom_range(0, 9) != 0);
            s  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 29) == 0);
            wi = $urandom_range(0, 12);
            wf = $urandom_range(0, 15);
            cyc(e, s, w, wi, wf);
            exp_out[3] = model_tick(e, s);
            exp_out[2] = exp_out[3] && ((m_n % OS) == OS / 2 - 1);
            exp_out[1] = exp_out[3] && ((m_n % OS) == OS - 1);
            exp_out[0] = m_pend;
            check($sformatf("rand_cyc%0d_tmbp", i), {tick, mid, bitt, pend}, exp_out);
            model_step(e, s, w, wi, wf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_generator_frac.md
Name: br_generator_frac

Overview:
- Next-generation UART baud-tick generator: oversampling tick at CLK_FREQ/(OVERSAMPLE*baud), divisor run-time programmable, with fractional accumulation so long-run tick rate error ≤ 1/2^FRAC_NBITS clock.
- Also derives per-bit and mid-bit strobes so TX/RX FSMs no longer count oversample ticks themselves.
- Phase can be realigned on RX start-bit detection.
- Sits between the clock/reset tree and the UART TX/RX blocks; one instance may serve both.

Parameters:
- CLK_FREQ, 100E6, input clock frequency in Hz.
- BAUD_RATE, 9600, baud rate used to compute the reset-default divisor.
- OVERSAMPLE, 16, o_tick pulses per bit; power of two, ≥4.
- INT_NBITS, 16, width of integer divisor.
- FRAC_NBITS, 4, width of fractional divisor and accumulator.
- DEF_INT, floor(CLK_FREQ/(OVERSAMPLE*BAUD_RATE)), reset integer divisor (651 at defaults).
- DEF_FRAC, round(fractional part * 2^FRAC_NBITS), reset fractional divisor (1 at defaults).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion assumed synchronised upstream.
- i_en  in  1  count enable; 0 freezes all counters, no strobes.
- i_sync  in  1  one-cycle phase restart request.
- i_div_wr  in  1  one-cycle divisor write strobe.
- i_div_int  in  INT_NBITS  new integer divisor, sampled when i_div_wr=1.
- i_div_frac  in  FRAC_NBITS  new fractional divisor, sampled when i_div_wr=1.
- o_tick  out  1  oversample strobe, one cycle wide.
- o_mid_tick  out  1  strobe on the oversample tick at mid-bit (sub-count OVERSAMPLE/2-1).
- o_bit_tick  out  1  strobe on the last oversample tick of each bit (sub-count OVERSAMPLE-1).
- o_div_pend  out  1  written divisor not yet applied.

Behaviour:
- State: down-counter cnt[INT_NBITS], accumulator acc[FRAC_NBITS], sub-counter sub[log2(OVERSAMPLE)], active divisor (aint, afrac), shadow divisor (sint, sfrac), pend flag.
- Reset (i_rst=0, immediate): aint=sint=DEF_INT, afrac=sfrac=DEF_FRAC, cnt=DEF_INT-1, acc=0, sub=0, pend=0; all outputs 0.
- o_tick = i_en & (cnt==0), combinational decode; o_mid_tick = o_tick & (sub==OVERSAMPLE/2-1); o_bit_tick = o_tick & (sub==OVERSAMPLE-1).
- i_en=1, cnt≠0: cnt decrements by 1.
- On o_tick: {carry,acc} = acc+afrac; cnt reloads aint-1+carry; sub increments, wraps OVERSAMPLE-1→0.
- Tick period is aint cycles, or aint+1 when the accumulator carries; average period is aint+afrac/2^FRAC_NBITS.
- i_en=0: cnt, acc and sub hold; no strobes; divisor writes still captured.
- Divisor write: i_div_wr=1 loads sint/sfrac and sets pend (a later write before apply overwrites the shadow).
  - Integer values <2 are clamped to 2 on capture.
  - Applied at the next o_tick or i_sync, whichever comes first: aint/afrac take the shadow, acc=0, sub=0, cnt=new aint-1, pend cleared the same edge.
  - If i_en=0, applied on the next clock edge instead.
- i_sync=1 (regardless of i_en): cnt=aint-1 (or shadow-1 if pend), acc=0, sub=0, pend applied/cleared.
  - No o_tick is produced in that cycle, even if cnt==0.
  - i_sync has priority over the tick reload.
- Simultaneous i_div_wr and apply event in the same cycle: the new write is applied directly (pend ends 0).
- Reset mid-operation: everything returns to reset state asynchronously, with no partial strobe.

Test Plan:
1. Defaults, i_en=1 after reset release -> first o_tick after 651 cycles; across 16 ticks, exactly one period is 652 cycles; first o_bit_tick on the 16th tick; o_mid_tick on the 8th.
2. Write int=10, frac=8 mid-period -> o_div_pend=1 until the next o_tick, then periods alternate 10,11; sub restarts so o_bit_tick comes on the 16th tick after apply.
3. i_en dropped for 100 cycles with cnt=5 -> no strobes, cnt resumes at 5; total period = aint+100.
4. i_sync pulse on the same cycle cnt==0 -> no o_tick; next o_tick exactly aint cycles later with sub=0.
5. Write int=0 -> clamped; applied period = 2 cycles, o_tick every other cycle.
6. Assert i_rst=0 asynchronously between edges during an o_tick cycle -> all outputs 0 immediately; o_div_pend=0; divisor back to 651/1.
